mem_block_copier: RTL and testbench

- Bus initiator for the word-addressed async memory interface (read/write/address/write_data/read_data, read data valid 7 ns after address/read change).
- Copies a block of words from a source region to a destination region, word by word: read, hold, capture, then write.
- Sits beside the multi_cycle_mips core as a second master; used by benches for preload/relocation without CPU involvement.

---
 rtl/mem_block_copier.sv | 200 ++++++++++++++++++++
 tb/tb_mem_block_copier.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_copier.sv
`timescale 1ns/1ps
// mem_block_copier
//
// Second bus master for the word-addressed asynchronous memory. It copies a
// block of words from a source region to a destination region. Each word is
// read, held, captured and then written. Benches use it to preload or
// relocate memory contents without involving the CPU.
//
// Request handshake (start / busy / done):
//   start is a one-cycle request. It is sampled only while the block is idle.
//   If start is high at an edge in IDLE, the request is accepted at that edge.
//   busy is high from the cycle after acceptance through the last WRITE cycle.
//   done pulses high for exactly one cycle when the copy completes.
//   For a zero-length copy, busy stays low and done pulses in the next cycle.
//   A start seen while busy, or during the done cycle, is dropped.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; aborts a copy in progress
//   start          copy request (see handshake above)
//   src_addr       source byte address; bits [1:0] are ignored
//   dst_addr       destination byte address; bits [1:0] are ignored
//   word_count     number of words to copy (0 is legal)
//   busy, done     status (see handshake above)
//   mem_addr       registered memory address
//   mem_read       registered read strobe
//   mem_write      registered write strobe; memory writes at the edge that
//                  ends the cycle
//   mem_write_data registered write data
//   mem_read_data  memory read data; sampled only at the capture edge
//
// Parameters:
//   READ_WAIT  number of cycles the read strobe and source address are held
//              before read data is captured. It must be >= 1 and must cover
//              the 7 ns memory access time at the clock period in use.
//   CNT_W      width of word_count
module mem_block_copier #(
    parameter int READ_WAIT = 3,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        src_ptr_q, src_ptr_d;
    logic [31:0]        dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_write_data_q, mem_write_data_d;

    // The two address LSBs are intentionally dropped (word alignment).
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        state_d          = state_q;
        src_ptr_d        = src_ptr_q;
        dst_ptr_d        = dst_ptr_q;
        remaining_d      = remaining_q;
        wait_d           = wait_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_write_data_d = mem_write_data_q;

        // All bus outputs are registered. Each transition therefore sets up
        // the strobes and address that belong to the state being entered.
        case (state_q)
            S_IDLE: begin
                busy_d      = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (start) begin
                    src_ptr_d   = {src_addr[31:2], 2'b00};
                    dst_ptr_d   = {dst_addr[31:2], 2'b00};
                    remaining_d = word_count;
                    wait_d      = '0;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        busy_d     = 1'b1;
                        mem_read_d = 1'b1;
                        mem_addr_d = {src_addr[31:2], 2'b00};
                    end
                end
            end

            S_READ: begin
                if (wait_q == WAIT_LAST) begin
                    // Capture edge. Read data has now settled for this
                    // address. This is the only path from mem_read_data
                    // into the write data register.
                    mem_write_data_d = mem_read_data;
                    state_d          = S_WRITE;
                    wait_d           = '0;
                    mem_read_d       = 1'b0;
                    mem_write_d      = 1'b1;
                    mem_addr_d       = dst_ptr_q;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_WRITE: begin
                // Both pointers wrap modulo 2^32.
                src_ptr_d   = src_ptr_q + 32'd4;
                dst_ptr_d   = dst_ptr_q + 32'd4;
                remaining_d = remaining_q - CNT_W'(1);
                mem_write_d = 1'b0;
                if (remaining_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_READ;
                    mem_read_d = 1'b1;
                    mem_addr_d = src_ptr_q + 32'd4;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            src_ptr_q        <= '0;
            dst_ptr_q        <= '0;
            remaining_q      <= '0;
            wait_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            mem_addr_q       <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            src_ptr_q        <= src_ptr_d;
            dst_ptr_q        <= dst_ptr_d;
            remaining_q      <= remaining_d;
            wait_q           <= wait_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            mem_addr_q       <= mem_addr_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_addr       = mem_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_block_copier.sv
`timescale 1ns/1ps
// Testbench for mem_block_copier.
// The bench contains the following pieces:
//   - A 1024-word memory with a 7 ns access time. Read data is valid only
//     once the address and read strobe have been stable long enough.
//   - A reference copy model built from plain array arithmetic.
//   - Expected read-address and write queues, checked on every bus cycle.
module tb_mem_block_copier;

    localparam int  READ_WAIT = 3;
    localparam int  CNT_W     = 10;
    localparam real T_CLK     = 2.5;
    localparam real T_ACC     = 7.0;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic [31:0]      mem_addr;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;

    mem_block_copier #(.READ_WAIT(READ_WAIT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #(T_CLK / 2.0) clk = ~clk;
    end

    // ---------------- state ----------------
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_rd_q[$];
    logic [63:0] exp_wr_q[$];

    int          n_vec;
    int          n_err;
    int          wr_seen;
    int          rd_run;
    int          hold;
    logic        prev_rd;
    logic [31:0] prev_addr;
    logic        pend_w;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- one bus cycle ----------------
    // Runs at the negedge. The step proceeds in four parts:
    //   1. Commit the write registered in the previous cycle. It is skipped
    //      when reset was high at that edge, because the shared reset
    //      suppresses the in-flight write.
    //   2. Check the bus against the expected queues.
    //   3. Record this cycle's write.
    //   4. Update read data for the upcoming capture edge.
    task automatic step();
        logic [63:0] w;
        @(negedge clk);
        if (pend_w && !reset) mem[pend_addr[11:2]] = pend_data;
        pend_w = 1'b0;

        check_eq("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);

        if (mem_read) begin
            rd_run++;
            if (exp_rd_q.size() == 0) check_eq("rd_unexpected", 64'(mem_read), 64'd0);
            else                      check_eq("rd_addr", 64'(mem_addr), 64'(exp_rd_q[0]));
        end

        if (mem_write) begin
            wr_seen++;
            check_eq("wdata_known", 64'($isunknown(mem_write_data)), 64'd0);
            check_eq("rd_hold_cycles", 64'(rd_run), 64'(READ_WAIT));
            rd_run = 0;
            if (exp_wr_q.size() == 0) begin
                check_eq("wr_unexpected", 64'(mem_write), 64'd0);
            end else begin
                w = exp_wr_q.pop_front();
                check_eq("wr_addr", 64'(mem_addr), 64'(w[63:32]));
                check_eq("wr_data", 64'(mem_write_data), 64'(w[31:0]));
            end
            if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_front());
            pend_w    = 1'b1;
            pend_addr = mem_addr;
            pend_data = mem_write_data;
        end

        // Access time model: data is valid at the next rising edge only if
        // address and strobe have been stable for at least T_ACC by then.
        if (mem_read && prev_rd && mem_addr == prev_addr) hold++;
        else                                             hold = 1;
        prev_rd   = mem_read;
        prev_addr = mem_addr;
        if (!mem_read)                       mem_read_data = 'x;
        else if (real'(hold) * T_CLK >= T_ACC) mem_read_data = mem[mem_addr[11:2]];
        else                                 mem_read_data = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"},  64'(busy), 64'd0);
        check_eq({tag, "_done"},  64'(done), 64'd0);
        check_eq({tag, "_rd"},    64'(mem_read), 64'd0);
        check_eq({tag, "_wr"},    64'(mem_write), 64'd0);
        check_eq({tag, "_addr"},  64'(mem_addr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(mem_write_data), 64'd0);
    endtask

    task automatic check_image(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check_eq(tag, 64'(diffs), 64'd0);
    endtask

    // ---------------- one copy transaction ----------------
    // The abort_k argument selects an abort: if nonzero, reset is raised
    // during the abort_k-th WRITE cycle.
    // The poke_busy and poke_done arguments inject extra start pulses while
    // busy or during the done cycle. These pulses must be ignored.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int abort_k, input bit poke_busy, input bit poke_done);
        logic [31:0] sa, da, v;
        int          k, busy_cnt, lat, si, di;
        bit          aborted;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        // Reference: forward word-by-word copy (overlap propagates).
        for (int i = 0; i < n; i++) begin
            if (abort_k > 0 && i >= abort_k) break;
            si = (int'(sa[11:2]) + i) % 1024;
            di = (int'(da[11:2]) + i) % 1024;
            v  = ref_mem[si];
            exp_rd_q.push_back(sa + 32'(4 * i));
            exp_wr_q.push_back({da + 32'(4 * i), v});
            if (abort_k == 0 || i < abort_k - 1) ref_mem[di] = v;
        end

        wr_seen    = 0;
        src_addr   = s;
        dst_addr   = d;
        word_count = CNT_W'(n);
        start      = 1'b1;
        step();
        start      = 1'b0;

        k        = 1;
        busy_cnt = 0;
        aborted  = 1'b0;
        lat      = n * (READ_WAIT + 1) + 1;
        while (!done && k < lat + 8) begin
            if (busy) busy_cnt++;
            if (abort_k > 0 && mem_write && wr_seen == abort_k) begin
                reset = 1'b1;
                step();
                check_outputs_zero("abort");
                reset = 1'b0;
                exp_rd_q.delete();
                exp_wr_q.delete();
                rd_run  = 0;
                aborted = 1'b1;
                break;
            end
            if (poke_busy && k == 2) begin
                start      = 1'b1;
                src_addr   = $urandom;
                dst_addr   = $urandom;
                word_count = CNT_W'($urandom_range(0, 5));
            end
            step();
            start = 1'b0;
            k++;
        end

        if (!aborted) begin
            check_eq("done_latency", 64'(k), 64'(lat));
            check_eq("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
            check_eq("busy_in_done", 64'(busy), 64'd0);
            if (poke_done) begin
                start      = 1'b1;
                src_addr   = $urandom;
                dst_addr   = $urandom;
                word_count = CNT_W'($urandom_range(1, 5));
            end
            step();
            start = 1'b0;
            check_eq("done_one_cycle", 64'(done), 64'd0);
            check_eq("idle_busy", 64'(busy), 64'd0);
            repeat (2) begin
                step();
                check_eq("idle_quiet", 64'({busy, done, mem_read, mem_write}), 64'd0);
            end
            check_eq("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
        end else begin
            repeat (2) step();
        end
        check_image("mem_image");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] s, d;
        int          n, mode;
        n_vec = 0; n_err = 0; wr_seen = 0; rd_run = 0; hold = 0;
        prev_rd = 1'b0; prev_addr = '0; pend_w = 1'b0; pend_addr = '0; pend_data = '0;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        mem_read_data = 'x;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        step();

        // Basic 4-word copy.
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
        for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
        run_copy(32'h0, 32'h100, 4, 0, 1'b0, 1'b0);
        check_eq("basic_w64", 64'(mem[64]), 64'd11);
        check_eq("basic_w67", 64'(mem[67]), 64'd44);

        // Zero-length copy.
        run_copy(32'h0, 32'h200, 0, 0, 1'b0, 1'b0);

        // Unaligned addresses.
        mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
        run_copy(32'h2, 32'h43, 1, 0, 1'b0, 1'b0);
        check_eq("unaligned_w16", 64'(mem[16]), 64'hDEADBEEF);

        // Reset during the 2nd WRITE cycle of a 5-word copy, then recopy.
        run_copy(32'h0, 32'h80, 5, 2, 1'b0, 1'b0);
        run_copy(32'h0, 32'h80, 5, 0, 1'b0, 1'b0);

        // Start pulses while busy and during done are ignored.
        run_copy(32'h10, 32'h300, 3, 0, 1'b1, 1'b1);

        // Overlapping forward copy propagates word 0.
        mem[0] = 32'hA; ref_mem[0] = 32'hA;
        run_copy(32'h0, 32'h4, 3, 0, 1'b0, 1'b0);
        check_eq("overlap_w1", 64'(mem[1]), 64'hA);
        check_eq("overlap_w3", 64'(mem[3]), 64'hA);

        // Pointer wrap at the top of the 32-bit address space.
        run_copy(32'hFFFF_FFF8, 32'h0000_0500, 4, 0, 1'b0, 1'b0);

        // Randomized copies.
        for (int t = 0; t < 16; t++) begin
            s    = $urandom;
            n    = $urandom_range(1, 10);
            mode = $urandom_range(0, 2);
            if (mode == 0)      d = $urandom;
            else if (mode == 1) d = s + 32'(4 * $urandom_range(1, 3));
            else                d = s - 32'(4 * $urandom_range(1, 3));
            run_copy(s, d, n, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
